// File: rtl/inst_queue_pkg.sv
// inst_queue shared types and helpers.
// Entry layout and width helpers used by the queue and its storage.
package inst_queue_pkg;

  localparam int INST_W  = 32;
  localparam int PC_W    = 32;
  localparam int ENTRY_W = PC_W + INST_W;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/inst_queue_if.sv
// inst_queue fetch/decode bundle.
// Master is the fetch+decode side, slave is the queue.
interface inst_queue_if #(
  parameter int FETCH_N = 2,
  parameter int ISSUE_N = 2,
  parameter int DEPTH   = 16
);
  import inst_queue_pkg::*;

  localparam int ICW = clog2(ISSUE_N + 1);
  localparam int CW  = clog2(DEPTH) + 1;

  logic                       flush;
  logic                       fetch_valid;
  logic [PC_W-1:0]            fetch_pc;
  logic [INST_W*FETCH_N-1:0]  fetch_rdata;
  logic                       fetch_ready;
  logic [ISSUE_N-1:0]         out_valid;
  logic [INST_W*ISSUE_N-1:0]  out_inst;
  logic [PC_W*ISSUE_N-1:0]    out_pc;
  logic [ICW-1:0]             issue_cnt;
  logic [CW-1:0]              count;

  modport master (
    output flush,
    output fetch_valid,
    output fetch_pc,
    output fetch_rdata,
    output issue_cnt,
    input  fetch_ready,
    input  out_valid,
    input  out_inst,
    input  out_pc,
    input  count
  );

  modport slave (
    input  flush,
    input  fetch_valid,
    input  fetch_pc,
    input  fetch_rdata,
    input  issue_cnt,
    output fetch_ready,
    output out_valid,
    output out_inst,
    output out_pc,
    output count
  );

endinterface

// File: rtl/inst_queue_ram.sv
// inst_queue entry storage.
// FETCH_N wrapping write ports, ISSUE_N async read ports.
module inst_queue_ram
  import inst_queue_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int FETCH_N = 2,
  parameter int ISSUE_N = 2,
  parameter int AW      = clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic [FETCH_N-1:0]         i_we,
  input  logic [AW-1:0]              i_waddr,
  input  entry_t [FETCH_N-1:0]       i_wdata,
  input  logic [AW-1:0]              i_raddr,
  output entry_t [ISSUE_N-1:0]       o_rdata
);

  entry_t r_mem [DEPTH];

  // write consecutive slots starting at i_waddr, wrapping mod DEPTH
  always_ff @(posedge clk) begin
    for (int p = 0; p < FETCH_N; p++) begin
      if (i_we[p]) begin
        r_mem[i_waddr + AW'(p)] <= i_wdata[p];
      end
    end
  end

  // read the ISSUE_N oldest slots starting at i_raddr
  always_comb begin
    for (int j = 0; j < ISSUE_N; j++) begin
      o_rdata[j] = r_mem[i_raddr + AW'(j)];
    end
  end

endmodule

// File: rtl/inst_queue.sv
// inst_queue: fetch-to-decode instruction buffer.
// Pointers, occupancy, pop clamp and fetch offset handling.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int FETCH_N = 2,
  parameter int ISSUE_N = 2,
  parameter int DEPTH   = 16
) (
  input  logic         clk,
  input  logic         rst,
  inst_queue_if.slave  io_q
);

  localparam int W  = clog2(FETCH_N);
  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [PW-1:0]          w_count;
  logic                   w_ready;
  logic                   w_push;
  logic [PW-1:0]          w_off;
  logic [PW-1:0]          w_k;
  logic [PW-1:0]          w_avail;
  logic [PW-1:0]          w_req;
  logic [PW-1:0]          w_pop;
  logic [PC_W-1:0]        w_base;
  logic [FETCH_N-1:0]     w_we;
  entry_t [FETCH_N-1:0]   w_wdata;
  entry_t [ISSUE_N-1:0]   w_rdata;

  // pointer difference is the occupancy; MSB disambiguates full/empty
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_ready = (w_count <= PW'(DEPTH - FETCH_N));
  assign w_push  = io_q.fetch_valid && w_ready && !io_q.flush;

  generate
    if (W > 0) begin : g_off
      assign w_off = PW'(io_q.fetch_pc[W+1:2]);
    end else begin : g_no_off
      assign w_off = '0;
    end
  endgenerate

  assign w_base = io_q.fetch_pc & ~PC_W'((1 << (W + 2)) - 1);
  assign w_k    = PW'(FETCH_N) - w_off;

  // decode may ask for more than is shown; clamp to visible slots
  assign w_avail = (w_count > PW'(ISSUE_N)) ? PW'(ISSUE_N) : w_count;
  assign w_req   = PW'(io_q.issue_cnt);
  assign w_pop   = (w_req > w_avail) ? w_avail : w_req;

  // route wanted packet words (off..FETCH_N-1) onto write ports 0..k-1
  always_comb begin
    int idx;
    idx     = 0;
    w_we    = '0;
    w_wdata = '0;
    for (int p = 0; p < FETCH_N; p++) begin
      idx = int'(w_off) + p;
      if (idx < FETCH_N) begin
        w_we[p]         = w_push;
        w_wdata[p].pc   = w_base + PC_W'(idx * 4);
        w_wdata[p].inst = io_q.fetch_rdata[idx*INST_W +: INST_W];
      end
    end
  end

  // pointer update; flush and reset both return to an empty queue at 0
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (io_q.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + w_k;
      end
      r_rd_ptr <= r_rd_ptr + w_pop;
    end
  end

  inst_queue_ram #(
    .DEPTH   (DEPTH),
    .FETCH_N (FETCH_N),
    .ISSUE_N (ISSUE_N),
    .AW      (AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (w_wdata),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_rdata)
  );

  // present the oldest entries; invalid slots read as zero
  always_comb begin
    io_q.out_valid = '0;
    io_q.out_inst  = '0;
    io_q.out_pc    = '0;
    for (int j = 0; j < ISSUE_N; j++) begin
      if (w_count > PW'(j)) begin
        io_q.out_valid[j]              = 1'b1;
        io_q.out_inst[j*INST_W +: INST_W] = w_rdata[j].inst;
        io_q.out_pc[j*PC_W +: PC_W]       = w_rdata[j].pc;
      end
    end
  end

  assign io_q.fetch_ready = w_ready;
  assign io_q.count       = w_count;

endmodule

// File: tb/tb_inst_queue.sv
// inst_queue bench: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int FN = 2;
  localparam int IN = 2;
  localparam int D  = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  inst_queue_if #(.FETCH_N(FN), .ISSUE_N(IN), .DEPTH(D)) q ();

  inst_queue #(
    .FETCH_N (FN),
    .ISSUE_N (IN),
    .DEPTH   (D)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .io_q (q)
  );

  int n_chk;
  int n_fail;

  logic [31:0] m_pc [$];
  logic [31:0] m_in [$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int sz;
    sz = m_pc.size();
    chk("count", 64'(q.count), 64'(sz));
    chk("ready", 64'(q.fetch_ready), 64'((D - sz) >= FN));
    for (int j = 0; j < IN; j++) begin
      chk($sformatf("valid%0d", j), 64'(q.out_valid[j]), 64'(j < sz));
      chk($sformatf("pc%0d", j), 64'(q.out_pc[j*32 +: 32]),
          64'((j < sz) ? m_pc[j] : 32'h0));
      chk($sformatf("inst%0d", j), 64'(q.out_inst[j*32 +: 32]),
          64'((j < sz) ? m_in[j] : 32'h0));
    end
  endtask

  // called at negedge: check, drive, advance model, wait next negedge
  task automatic step(input logic r, input logic f, input logic fv,
                      input logic [31:0] pc, input logic [63:0] data,
                      input int ic);
    int sz, avail, npop, off;
    logic rdy;
    logic [31:0] base;
    check_all();
    rst           = r;
    q.flush       = f;
    q.fetch_valid = fv;
    q.fetch_pc    = pc;
    q.fetch_rdata = data;
    q.issue_cnt   = ic[1:0];
    if (r || f) begin
      m_pc.delete();
      m_in.delete();
    end else begin
      sz    = m_pc.size();
      rdy   = (D - sz) >= FN;
      avail = (sz < IN) ? sz : IN;
      npop  = (ic < avail) ? ic : avail;
      repeat (npop) begin
        void'(m_pc.pop_front());
        void'(m_in.pop_front());
      end
      if (fv && rdy) begin
        off  = (pc >> 2) % FN;
        base = pc & ~32'(FN * 4 - 1);
        for (int i = off; i < FN; i++) begin
          m_pc.push_back(base + 32'(4 * i));
          m_in.push_back(data[i*32 +: 32]);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int ic);
    step(1'b0, 1'b0, 1'b0, 32'h0, 64'h0, ic);
  endtask

  task automatic push(input logic [31:0] pc, input int ic);
    step(1'b0, 1'b0, 1'b1, pc, {$urandom, $urandom}, ic);
  endtask

  task automatic do_flush();
    step(1'b0, 1'b1, 1'b0, 32'h0, 64'h0, 0);
  endtask

  initial begin
    logic [31:0] exp_pc;
    n_chk  = 0;
    n_fail = 0;
    rst           = 1'b1;
    q.flush       = 1'b0;
    q.fetch_valid = 1'b0;
    q.fetch_pc    = '0;
    q.fetch_rdata = '0;
    q.issue_cnt   = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_count", 64'(q.count), 64'd0);
    chk("rst_ready", 64'(q.fetch_ready), 64'd1);
    chk("rst_valid", 64'(q.out_valid), 64'd0);
    chk("rst_pc", 64'(q.out_pc), 64'd0);
    chk("rst_inst", 64'(q.out_inst), 64'd0);
    rst = 1'b0;

    // aligned packet
    step(1'b0, 1'b0, 1'b1, 32'h100, {32'h22222222, 32'h11111111}, 0);
    chk("t1_valid", 64'(q.out_valid), 64'd3);
    chk("t1_pc0", 64'(q.out_pc[31:0]), 64'h100);
    chk("t1_in0", 64'(q.out_inst[31:0]), 64'h11111111);
    chk("t1_pc1", 64'(q.out_pc[63:32]), 64'h104);
    chk("t1_in1", 64'(q.out_inst[63:32]), 64'h22222222);
    chk("t1_count", 64'(q.count), 64'd2);
    do_flush();

    // misaligned packet keeps only the upper word
    step(1'b0, 1'b0, 1'b1, 32'h204, {32'hBBBBBBBB, 32'hAAAAAAAA}, 0);
    chk("t2_count", 64'(q.count), 64'd1);
    chk("t2_valid", 64'(q.out_valid), 64'd1);
    chk("t2_pc0", 64'(q.out_pc[31:0]), 64'h204);
    chk("t2_in0", 64'(q.out_inst[31:0]), 64'hBBBBBBBB);
    do_flush();

    // fill to full, then push blocked while popping
    for (int i = 0; i < 8; i++) push(32'h300 + 32'(8 * i), 0);
    chk("t3_full", 64'(q.count), 64'd16);
    chk("t3_nrdy", 64'(q.fetch_ready), 64'd0);
    push(32'h400, 2);
    chk("t3_count", 64'(q.count), 64'd14);
    chk("t3_rdy", 64'(q.fetch_ready), 64'd1);
    chk("t3_pc0", 64'(q.out_pc[31:0]), 64'h308);
    do_flush();

    // wrap-around: alternate push-2 / pop-2
    exp_pc = 32'h1000;
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) begin
        push(32'h1000 + 32'(4 * i), 0);
      end else begin
        chk("wrap_v", 64'(q.out_valid), 64'd3);
        chk("wrap_pc0", 64'(q.out_pc[31:0]), 64'(exp_pc));
        chk("wrap_pc1", 64'(q.out_pc[63:32]), 64'(exp_pc + 32'd4));
        exp_pc = exp_pc + 32'd8;
        idle(2);
      end
    end

    // flush at count 9 beats a same-cycle push and pop
    for (int i = 0; i < 4; i++) push(32'h2000 + 32'(8 * i), 0);
    push(32'h2024, 0);
    chk("t5_pre", 64'(q.count), 64'd9);
    step(1'b0, 1'b1, 1'b1, 32'h3000, 64'h1, 2);
    chk("t5_count", 64'(q.count), 64'd0);
    chk("t5_valid", 64'(q.out_valid), 64'd0);
    chk("t5_pc", 64'(q.out_pc), 64'd0);

    // single entry, oversized pop
    push(32'h504, 0);
    chk("t6_pre", 64'(q.count), 64'd1);
    idle(3);
    chk("t6_count", 64'(q.count), 64'd0);
    idle(3);
    chk("t6_empty", 64'(q.count), 64'd0);

    // reset mid-stream
    push(32'h600, 0);
    push(32'h608, 1);
    step(1'b1, 1'b0, 1'b1, 32'h610, 64'h5, 1);
    chk("t7_count", 64'(q.count), 64'd0);
    chk("t7_ready", 64'(q.fetch_ready), 64'd1);
    chk("t7_valid", 64'(q.out_valid), 64'd0);
    chk("t7_inst", 64'(q.out_inst), 64'd0);
    rst = 1'b0;

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 300) == 0,
           ($urandom % 60) == 0,
           ($urandom % 4) != 0,
           $urandom & 32'hFFFF_FFFC,
           {$urandom, $urandom},
           int'($urandom_range(0, 3)));
    end
    check_all();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
